bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data width of both requester ports and the BRAM port.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; the BRAM depth is 2^ADDR_W words.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_a, req_b  in  1 each  SHALL each signal a pending access from requester A or B.
REQ-006 we_a, we_b  in  1 each  SHALL select the access type: 1 = write, 0 = read.
REQ-007 addr_a, addr_b  in  ADDR_W each  SHALL carry the word address.
REQ-008 wdata_a, wdata_b  in  DATA_W each  SHALL carry the write data.
REQ-009 gnt_a, gnt_b  out  1 each  SHALL acknowledge acceptance of the request in the current cycle.
REQ-010 rvalid_a, rvalid_b  out  1 each  SHALL pulse high for one cycle when read data is returned.
REQ-011 rdata_a, rdata_b  out  DATA_W each  SHALL carry the returned read data, qualified by rvalid.
REQ-012 bram_en, bram_we  out  1 each  SHALL drive the BRAM enable and write-enable.
REQ-013 bram_addr  out  ADDR_W  SHALL drive the BRAM address.
REQ-014 bram_din  out  DATA_W  SHALL drive the BRAM write data.
REQ-015 bram_dout  in  DATA_W  SHALL be the BRAM read data, valid one cycle after a read enable.

Function
REQ-016 Handshake: a requester SHALL hold req/we/addr/wdata stable until it samples gnt high; the transfer is accepted in the cycle where req & gnt = 1.
REQ-017 gnt SHALL be combinational from req and the priority pointer; at most one gnt SHALL be high per cycle, and gnt_x SHALL never be high without req_x.
REQ-018 Arbitration SHALL be round-robin: with only one request pending, that requester is granted; with both pending, the requester not granted most recently is granted.
REQ-019 The priority pointer SHALL update only on a grant, to favour the other requester; it SHALL hold when there is no grant.
REQ-020 Issue stage: in the cycle after acceptance, bram_en = 1, and bram_we, bram_addr, bram_din SHALL equal the accepted we/addr/wdata, all registered.
REQ-021 With no acceptance in the previous cycle, bram_en and bram_we SHALL be 0; bram_addr and bram_din SHALL hold their last values.
REQ-022 Read return: for a read accepted in cycle N, the arbiter SHALL capture bram_dout in cycle N+2; rvalid_x = 1 and rdata_x = the data SHALL appear in cycle N+3, on the originating requester's port only.
REQ-023 A write SHALL produce no rvalid.
REQ-024 Rdata SHALL hold its last value while rvalid is low.
REQ-025 Throughput: one acceptance per cycle SHALL be sustained; the pipeline SHALL carry up to 3 in-flight accesses, each tagged with its requester id.
REQ-026 Accesses SHALL reach the BRAM in acceptance order, so a read accepted after a write to the same address returns the new data.
REQ-027 Back-to-back reads from the same requester SHALL return rvalid on consecutive cycles, in order.
REQ-028 Reads from A and B granted in alternate cycles SHALL return in alternate cycles with correct routing.

Reset
REQ-029 While rst_n = 0 at a rising edge, the following SHALL be 0 after that edge: bram_en, bram_we, bram_addr, bram_din, rvalid_a, rvalid_b, rdata_a, rdata_b, all pipeline valid bits, and the priority pointer (A favoured).
REQ-030 During reset, gnt_a and gnt_b SHALL be 0.
REQ-031 In-flight accesses SHALL be discarded on reset; no rvalid SHALL be produced for any request accepted before reset.

Verification
REQ-032 Scenario 1: after reset, A writes 0xFFFFFFFF to addr 0, then reads addr 0 -> rvalid_a pulses 3 cycles after the read gnt, with rdata_a = 0xFFFFFFFF; rvalid_b stays 0.
REQ-033 Scenario 2: req_a and req_b held continuously for 8 cycles -> grants strictly alternate A,B,A,B... starting with A; there is never a double grant.
REQ-034 Scenario 3: B writes 0x1..0x13 to addrs 1..19 (one accepted per cycle), then reads them back-to-back -> 19 consecutive rvalid_b pulses returning 0x1..0x13 in order.
REQ-035 Scenario 4: A writes 0x5 to addr 7 and B reads addr 7 in the next grant -> rdata_b = 0x5 (ordering preserved).
REQ-036 Scenario 5: rst_n driven low one cycle after a read is accepted -> no rvalid occurs in the following 4 cycles, and all outputs are 0 during reset.
REQ-037 Scenario 6: no requests for 5 cycles -> bram_en = 0 throughout and the priority pointer is unchanged.

Source files
------------

// File: rtl/bram_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and a single-port BRAM.
// slave = arbiter side; master = requesters plus the BRAM model.
interface bram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_a, req_b;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              gnt_a, gnt_b;
  logic              rvalid_a, rvalid_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, bram_dout,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
           bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, bram_dout,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
           bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM with a
// 3-stage tagged pipeline (issue, capture, return) for read data routing.
module bram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  bram_arbiter_if.slave bus
);

  logic              prio_b_r;
  logic              gnt_a_s, gnt_b_s;
  logic              acc_s, acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_din_s;

  logic              bram_en_r, bram_we_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic [DATA_W-1:0] bram_din_r;
  logic              issue_rd_r, issue_id_r;
  logic              cap_rd_r, cap_id_r;
  logic              rvalid_a_r, rvalid_b_r;
  logic [DATA_W-1:0] rdata_a_r, rdata_b_r;

  // Round-robin grant; prio_b_r set means B wins a tie.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (!rst_n) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else if (bus.req_a && (!bus.req_b || !prio_b_r)) begin
      gnt_a_s = 1'b1;
    end else if (bus.req_b) begin
      gnt_b_s = 1'b1;
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Select the fields of the accepted request.
  always_comb begin
    acc_s = gnt_a_s | gnt_b_s;
    if (gnt_b_s) begin
      acc_we_s   = bus.we_b;
      acc_addr_s = bus.addr_b;
      acc_din_s  = bus.wdata_b;
    end else begin
      acc_we_s   = bus.we_a;
      acc_addr_s = bus.addr_a;
      acc_din_s  = bus.wdata_a;
    end
  end

  // Priority pointer and BRAM issue stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_b_r    <= 1'b0;
      bram_en_r   <= 1'b0;
      bram_we_r   <= 1'b0;
      bram_addr_r <= {ADDR_W{1'b0}};
      bram_din_r  <= {DATA_W{1'b0}};
    end else begin
      if (gnt_a_s) begin
        prio_b_r <= 1'b1;
      end else if (gnt_b_s) begin
        prio_b_r <= 1'b0;
      end else begin
        prio_b_r <= prio_b_r;
      end
      bram_en_r <= acc_s;
      bram_we_r <= acc_s & acc_we_s;
      if (acc_s) begin
        bram_addr_r <= acc_addr_s;
        bram_din_r  <= acc_din_s;
      end else begin
        bram_addr_r <= bram_addr_r;
        bram_din_r  <= bram_din_r;
      end
    end
  end

  // Read tags follow the access through issue and capture; id 1 = B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_rd_r <= 1'b0;
      issue_id_r <= 1'b0;
      cap_rd_r   <= 1'b0;
      cap_id_r   <= 1'b0;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      rdata_a_r  <= {DATA_W{1'b0}};
      rdata_b_r  <= {DATA_W{1'b0}};
    end else begin
      issue_rd_r <= acc_s & ~acc_we_s;
      issue_id_r <= gnt_b_s;
      cap_rd_r   <= issue_rd_r;
      cap_id_r   <= issue_id_r;
      rvalid_a_r <= cap_rd_r & ~cap_id_r;
      rvalid_b_r <= cap_rd_r & cap_id_r;
      if (cap_rd_r && !cap_id_r) begin
        rdata_a_r <= bus.bram_dout;
      end else begin
        rdata_a_r <= rdata_a_r;
      end
      if (cap_rd_r && cap_id_r) begin
        rdata_b_r <= bus.bram_dout;
      end else begin
        rdata_b_r <= rdata_b_r;
      end
    end
  end

  assign bus.gnt_a     = gnt_a_s;
  assign bus.gnt_b     = gnt_b_s;
  assign bus.bram_en   = bram_en_r;
  assign bus.bram_we   = bram_we_r;
  assign bus.bram_addr = bram_addr_r;
  assign bus.bram_din  = bram_din_r;
  assign bus.rvalid_a  = rvalid_a_r;
  assign bus.rvalid_b  = rvalid_b_r;
  assign bus.rdata_a   = rdata_a_r;
  assign bus.rdata_b   = rdata_b_r;

endmodule
